// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full-subtractor cell: diff = a ^ b ^ bin, borrow out when a < b + bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), one bit per clock through one cell,
// with valid/ready on both the operand and the result side.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] diff_sh_reg;
  logic             borrow_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic             bout_reg;
  logic             ovf_reg;

  logic             cell_d;
  logic             cell_bo;
  logic             last_bit;

  full_subtractor u_cell (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .bin  (borrow_reg),
    .diff (cell_d),
    .bout (cell_bo)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand MSBs are kept aside because the shift registers are consumed by the time ovf is formed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      a_sh_reg    <= '0;
      b_sh_reg    <= '0;
      diff_sh_reg <= '0;
      borrow_reg  <= 1'b0;
      a_msb_reg   <= 1'b0;
      b_msb_reg   <= 1'b0;
      bout_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            borrow_reg <= bin;
            cnt_reg    <= '0;
            a_msb_reg  <= a[WIDTH-1];
            b_msb_reg  <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          diff_sh_reg <= {cell_d, diff_sh_reg[WIDTH-1:1]};
          a_sh_reg    <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg    <= {1'b0, b_sh_reg[WIDTH-1:1]};
          borrow_reg  <= cell_bo;
          if (last_bit) begin
            // cell_d is the result MSB on the final bit, so ovf can be formed here.
            bout_reg <= cell_bo;
            ovf_reg  <= (a_msb_reg ^ b_msb_reg) & (cell_d ^ a_msb_reg);
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff = diff_sh_reg;
  assign bout = bout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes model results on accept, monitor pops on handshake.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   nres  = 0;
  res_t exp_q[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the unsigned and signed interpretations.
  function automatic res_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic c);
    res_t        r;
    int          uf;
    int          sf;
    logic [31:0] tmp;
    uf     = int'(av) - int'(bv) - int'(c);
    sf     = int'($signed(av)) - int'($signed(bv)) - int'(c);
    tmp    = uf;
    r.diff = tmp[WIDTH-1:0];
    r.bout = (uf < 0);
    r.ovf  = (sf < -(2 ** (WIDTH - 1))) || (sf > (2 ** (WIDTH - 1)) - 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  // Presents an operand pair until accepted; returns the cycle index of the accepting edge.
  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic c,
                      output int acc_cyc);
    int   n;
    logic acc;
    n        = 0;
    acc      = 1'b0;
    acc_cyc  = -1;
    a        = av;
    b        = bv;
    bin      = c;
    in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      timeout_fail("accept");
    end else begin
      exp_q.push_back(model(av, bv, c));
      acc_cyc = cyc;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) timeout_fail("drain");
  endtask

  // Monitor: every result handshake is checked against the oldest outstanding expectation.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_result: got diff=%0h bout=%0b ovf=%0b, expected none",
                   diff, bout, ovf);
        end else begin
          r = exp_q.pop_front();
          nres++;
          $display("[TB] result %0d: diff=%02h bout=%0b ovf=%0b", nres, diff, bout, ovf);
          check("result", {diff, bout, ovf}, {r.diff, r.bout, r.ovf});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int               t;
    int               prev;
    int               n;
    logic             seen;
    res_t             r;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] edge_vals[4];

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    edge_vals[0] = '0;
    edge_vals[1] = '1;
    edge_vals[2] = {1'b1, {(WIDTH-1){1'b0}}};
    edge_vals[3] = {1'b0, {(WIDTH-1){1'b1}}};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {in_ready, out_valid, diff, bout, ovf, busy},
          {1'b1, 1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency counted in rising edges, the accepting edge included.
    send(8'h05, 8'h03, 1'b0, t);
    n    = 1;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("latency", n, WIDTH + 1);

    send(8'h00, 8'h01, 1'b0, t);
    send(8'h80, 8'h01, 1'b0, t);
    send(8'h10, 8'h0F, 1'b1, t);
    drain();

    // Backpressure: result must hold while in_valid pulses are ignored.
    out_ready = 1'b0;
    send(8'h7F, 8'hFF, 1'b0, t);
    r    = model(8'h7F, 8'hFF, 1'b0);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = out_valid;
      n++;
    end
    if (!seen) timeout_fail("bp_wait_done");
    for (int k = 0; k < 5; k++) begin
      check("bp_hold", {out_valid, in_ready, busy, diff, bout, ovf},
            {1'b1, 1'b0, 1'b1, r.diff, r.bout, r.ovf});
      @(posedge clk);
      #1;
      in_valid = (k % 2 == 0);
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {in_ready, out_valid, busy}, {1'b1, 1'b0, 1'b0});

    // Reset while bit 3 is being processed discards the operation.
    send(8'h5A, 8'h33, 1'b0, t);
    repeat (3) @(posedge clk);
    #1;
    check("mid_shift_busy", {busy, in_ready}, {1'b1, 1'b0});
    rst = 1'b1;
    #1;
    check("mid_shift_reset", {out_valid, busy, in_ready, diff, bout, ovf},
          {1'b0, 1'b0, 1'b1, {WIDTH{1'b0}}, 1'b0, 1'b0});
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h0A, 8'h04, 1'b0, t);
    drain();

    // Random back-to-back stream; accepts must be exactly WIDTH+2 clocks apart.
    prev = -1;
    for (int i = 0; i < 1000; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 3)] : WIDTH'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 3)] : WIDTH'($urandom);
      send(ra, rb, 1'($urandom), t);
      if (prev >= 0 && t >= 0) check("throughput", t - prev, WIDTH + 2);
      prev = t;
    end
    drain();
    repeat (20) @(posedge clk);
    #1;
    check("final_idle", {in_ready, out_valid, busy}, {1'b1, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
